// File: rtl/xmtbuffer.sv
// xmtbuffer: deserializes the 1200 bit/s loopback stream LSB first, queues bytes and hands them to the UART THR via TBRE/load.
// Optional XMTBUF_ZERO_SUPPRESS_EN drops completed 8'h00 (flush padding) bytes.
module xmtbuffer #(
  parameter int DEPTH = 16,
  parameter int AW = 4
) (
  input  logic          xmtbuf_clk,
  input  logic          rst,
  input  logic          clk_1200,
  input  logic          databit,
  input  logic          frame_valid,
  input  logic          tbre,
  output logic [7:0]    thr,
  output logic          thr_load,
  output logic [AW:0]   fifo_count,
  output logic          overflow
);
  typedef enum logic [1:0] {IDLE, LOAD, WAIT} state_t;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  state_t state, state_nx;
  logic [2:0] c_sync;
  logic [1:0] d_sync, f_sync;
  logic [7:0] sr, byte_nx;
  logic [2:0] bit_cnt;
  logic [7:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic bit_strobe, byte_done, keep, full, push, pop;
  // falling edge of the synchronized bit clock lands mid-bit
  assign bit_strobe = !c_sync[1] && c_sync[2];
  assign byte_nx = {d_sync[1], sr[7:1]};
  assign byte_done = bit_strobe && f_sync[1] && bit_cnt == 3'd7;
`ifdef XMTBUF_ZERO_SUPPRESS_EN
  assign keep = byte_nx != 8'h00;
`else
  assign keep = 1'b1;
`endif
  assign full = fifo_count == FULL_CNT;
  assign push = byte_done && keep && !full;
  assign pop = state == LOAD;
  always_ff @(posedge xmtbuf_clk or posedge rst) begin
    if (rst) begin
      c_sync <= '0;
      d_sync <= '0;
      f_sync <= '0;
      sr <= '0;
      bit_cnt <= '0;
    end else begin
      c_sync <= {c_sync[1:0], clk_1200};
      d_sync <= {d_sync[0], databit};
      f_sync <= {f_sync[0], frame_valid};
      if (bit_strobe) begin
        sr <= f_sync[1] ? byte_nx : sr;
        bit_cnt <= f_sync[1] ? bit_cnt + 3'd1 : 3'd0;
      end
    end
  end
  always_ff @(posedge xmtbuf_clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fifo_count <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      fifo_count <= fifo_count + (AW+1)'(push) - (AW+1)'(pop);
      if (byte_done && keep && full) overflow <= 1'b1;
    end
  end
  always_ff @(posedge xmtbuf_clk) begin
    if (push) mem[wr_ptr] <= byte_nx;
  end
  always_ff @(posedge xmtbuf_clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      thr <= '0;
      thr_load <= 1'b0;
    end else begin
      state <= state_nx;
      thr_load <= pop;
      if (pop) thr <= mem[rd_ptr];
    end
  end
  always_comb begin
    state_nx = state;
    if (state == IDLE && fifo_count != '0 && tbre) state_nx = LOAD;
    else if (state == LOAD) state_nx = WAIT;
    else if (state == WAIT && !tbre) state_nx = IDLE;
  end
endmodule

// File: tb/tb_xmtbuffer.sv
// tb_xmtbuffer: scoreboard bench for xmtbuffer; honours XMTBUF_ZERO_SUPPRESS_EN for the zero-byte scenario.
module tb_xmtbuffer;
  logic xmtbuf_clk = 0, rst = 1, clk_1200 = 0, databit = 0, frame_valid = 0, tbre = 0;
  logic [7:0] thr;
  logic thr_load;
  logic [4:0] fifo_count;
  logic overflow;
  int total = 0, bad = 0, loads = 0, rd = 0, one_cnt = 0;
  logic [7:0] got [0:255];
  logic [7:0] exp_q [$];
  logic [7:0] e;

  xmtbuffer #(.DEPTH(16), .AW(4)) dut (
    .xmtbuf_clk(xmtbuf_clk), .rst(rst), .clk_1200(clk_1200), .databit(databit),
    .frame_valid(frame_valid), .tbre(tbre), .thr(thr), .thr_load(thr_load),
    .fifo_count(fifo_count), .overflow(overflow)
  );

  always #5 xmtbuf_clk = ~xmtbuf_clk;

  // captures every byte the UART would latch
  always @(negedge xmtbuf_clk) begin
    if (thr_load) begin
      got[loads] = thr;
      loads++;
    end
    if (fifo_count == 5'd1) one_cnt++;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge xmtbuf_clk);
  endtask

  task automatic send_bit(input logic b);
    databit = b;
    clk_1200 = 1;
    cyc(16);
    clk_1200 = 0;
    cyc(16);
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 0; i < 8; i++) send_bit(v[i]);
  endtask

  task automatic uart_take(input int n);
    int l0;
    for (int k = 0; k < n; k++) begin
      l0 = loads;
      tbre = 1;
      for (int i = 0; i < 40 && loads == l0; i++) cyc(1);
      total++;
      if (loads == l0) begin
        bad++;
        $display("FAIL uart_take timeout: loads=%0d required>%0d", loads, l0);
      end
      tbre = 0;
      cyc(3);
    end
  endtask

  task automatic test_reset();
    cyc(3);
    total += 4;
    if (fifo_count !== 5'd0) begin bad++; $display("FAIL reset_count: got %0d want 0", fifo_count); end
    if (overflow !== 1'b0) begin bad++; $display("FAIL reset_ovf: got %b want 0", overflow); end
    if (thr !== 8'h00) begin bad++; $display("FAIL reset_thr: got %h want 00", thr); end
    if (thr_load !== 1'b0) begin bad++; $display("FAIL reset_load: got %b want 0", thr_load); end
    rst = 0;
    frame_valid = 1;
    cyc(4);
  endtask

  task automatic test_single();
    int l0, c0;
    l0 = loads;
    c0 = one_cnt;
    tbre = 1;
    send_byte(8'hA5);
    exp_q.push_back(8'hA5);
    cyc(10);
    total += 3;
    if (loads - l0 != 1) begin bad++; $display("FAIL single_loads: got %0d want 1", loads - l0); end
    if (one_cnt == c0) begin bad++; $display("FAIL single_count1: fifo_count never 1"); end
    if (fifo_count !== 5'd0) begin bad++; $display("FAIL single_count0: got %0d want 0", fifo_count); end
    tbre = 0;
    cyc(10);
    total++;
    if (loads - l0 != 1) begin bad++; $display("FAIL single_once: got %0d want 1", loads - l0); end
    while (rd < loads) begin
      total++;
      e = exp_q.size() ? exp_q.pop_front() : 8'hxx;
      if (got[rd] !== e) begin bad++; $display("FAIL single_data: got %h want %h", got[rd], e); end
      rd++;
    end
    total++;
    if (exp_q.size() != 0) begin bad++; $display("FAIL single_missing: %0d bytes not output", exp_q.size()); end
  endtask

  task automatic test_zero();
    logic [7:0] pat [3] = '{8'h00, 8'h7E, 8'h00};
    tbre = 0;
    foreach (pat[i]) begin
      send_byte(pat[i]);
`ifdef XMTBUF_ZERO_SUPPRESS_EN
      if (pat[i] != 8'h00) exp_q.push_back(pat[i]);
`else
      exp_q.push_back(pat[i]);
`endif
    end
    total++;
    if (fifo_count !== 5'(exp_q.size())) begin bad++; $display("FAIL zero_count: got %0d want %0d", fifo_count, exp_q.size()); end
    uart_take(exp_q.size());
    while (rd < loads) begin
      total++;
      e = exp_q.size() ? exp_q.pop_front() : 8'hxx;
      if (got[rd] !== e) begin bad++; $display("FAIL zero_data: got %h want %h", got[rd], e); end
      rd++;
    end
    total++;
    if (exp_q.size() != 0) begin bad++; $display("FAIL zero_missing: %0d bytes not output", exp_q.size()); end
  endtask

  task automatic test_frame_drop();
    tbre = 0;
    for (int i = 0; i < 5; i++) send_bit(1'b1);
    frame_valid = 0;
    send_bit(1'b1);
    send_bit(1'b0);
    frame_valid = 1;
    cyc(4);
    send_byte(8'h3C);
    exp_q.push_back(8'h3C);
    total++;
    if (fifo_count !== 5'd1) begin bad++; $display("FAIL frame_count: got %0d want 1", fifo_count); end
    uart_take(1);
    while (rd < loads) begin
      total++;
      e = exp_q.size() ? exp_q.pop_front() : 8'hxx;
      if (got[rd] !== e) begin bad++; $display("FAIL frame_data: got %h want %h", got[rd], e); end
      rd++;
    end
    total++;
    if (exp_q.size() != 0) begin bad++; $display("FAIL frame_missing: %0d bytes not output", exp_q.size()); end
  endtask

  task automatic test_overflow();
    int l0;
    tbre = 0;
    for (int v = 1; v <= 17; v++) begin
      send_byte(8'(v));
      if (exp_q.size() < 16) exp_q.push_back(8'(v));
      if (v == 16) begin
        total++;
        if (overflow !== 1'b0) begin bad++; $display("FAIL ovf_early: got %b want 0", overflow); end
      end
    end
    total += 2;
    if (fifo_count !== 5'd16) begin bad++; $display("FAIL ovf_count: got %0d want 16", fifo_count); end
    if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_flag: got %b want 1", overflow); end
    uart_take(16);
    l0 = loads;
    tbre = 1;
    cyc(40);
    tbre = 0;
    cyc(3);
    total += 3;
    if (loads != l0) begin bad++; $display("FAIL ovf_extra: got %0d extra loads want 0", loads - l0); end
    if (fifo_count !== 5'd0) begin bad++; $display("FAIL ovf_drained: got %0d want 0", fifo_count); end
    if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_sticky: got %b want 1", overflow); end
    while (rd < loads) begin
      total++;
      e = exp_q.size() ? exp_q.pop_front() : 8'hxx;
      if (got[rd] !== e) begin bad++; $display("FAIL ovf_data: got %h want %h", got[rd], e); end
      rd++;
    end
    total++;
    if (exp_q.size() != 0) begin bad++; $display("FAIL ovf_missing: %0d bytes not output", exp_q.size()); end
  endtask

  task automatic test_back_to_back();
    int l0;
    logic [7:0] pat [3] = '{8'h11, 8'h22, 8'h33};
    tbre = 0;
    foreach (pat[i]) begin
      send_byte(pat[i]);
      exp_q.push_back(pat[i]);
    end
    total++;
    if (fifo_count !== 5'd3) begin bad++; $display("FAIL b2b_count: got %0d want 3", fifo_count); end
    l0 = loads;
    for (int k = 1; k <= 3; k++) begin
      tbre = 1;
      cyc(60);
      total++;
      if (loads - l0 != k) begin bad++; $display("FAIL b2b_loads: got %0d want %0d", loads - l0, k); end
      tbre = 0;
      cyc(3);
    end
    while (rd < loads) begin
      total++;
      e = exp_q.size() ? exp_q.pop_front() : 8'hxx;
      if (got[rd] !== e) begin bad++; $display("FAIL b2b_data: got %h want %h", got[rd], e); end
      rd++;
    end
    total++;
    if (exp_q.size() != 0) begin bad++; $display("FAIL b2b_missing: %0d bytes not output", exp_q.size()); end
  endtask

  task automatic test_async_reset();
    logic [7:0] pat [4] = '{8'h81, 8'h42, 8'h24, 8'h18};
    tbre = 0;
    foreach (pat[i]) send_byte(pat[i]);
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    total += 3;
    if (fifo_count !== 5'd4) begin bad++; $display("FAIL arst_pre_count: got %0d want 4", fifo_count); end
    if (overflow !== 1'b1) begin bad++; $display("FAIL arst_pre_ovf: got %b want 1", overflow); end
    if (thr !== 8'h33) begin bad++; $display("FAIL arst_pre_thr: got %h want 33", thr); end
    #2 rst = 1;
    #1;
    total += 4;
    if (fifo_count !== 5'd0) begin bad++; $display("FAIL arst_count: got %0d want 0", fifo_count); end
    if (overflow !== 1'b0) begin bad++; $display("FAIL arst_ovf: got %b want 0", overflow); end
    if (thr !== 8'h00) begin bad++; $display("FAIL arst_thr: got %h want 00", thr); end
    if (thr_load !== 1'b0) begin bad++; $display("FAIL arst_load: got %b want 0", thr_load); end
    cyc(3);
    rst = 0;
    frame_valid = 0;
    cyc(4);
    frame_valid = 1;
    cyc(4);
    send_byte(8'h5A);
    exp_q.push_back(8'h5A);
    total++;
    if (fifo_count !== 5'd1) begin bad++; $display("FAIL arst_post_count: got %0d want 1", fifo_count); end
    uart_take(1);
    while (rd < loads) begin
      total++;
      e = exp_q.size() ? exp_q.pop_front() : 8'hxx;
      if (got[rd] !== e) begin bad++; $display("FAIL arst_data: got %h want %h", got[rd], e); end
      rd++;
    end
    total++;
    if (exp_q.size() != 0) begin bad++; $display("FAIL arst_missing: %0d bytes not output", exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_zero();
    test_frame_drop();
    test_overflow();
    test_back_to_back();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
